// File: rtl/nbody_pkg.sv
// Shared types for the n-body Verlet integrator: 3-vector of reals and the step FSM states.
package nbody_pkg;

  typedef real vec3_t [3];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_KICK,
    ST_DRIFT,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/nbody_vec3_axpy.sv
// Combinational r = y + a*x on a 3-vector; one instance serves both KICK and DRIFT.
module nbody_vec3_axpy
  import nbody_pkg::*;
(
  input  vec3_t y,
  input  vec3_t x,
  input  real   a,
  output vec3_t r
);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      r[k] = y[k] + a * x[k];
    end
  end

endmodule

// File: rtl/nbody_verlet_integrator.sv
// Kick-drift integrator: accumulates force beats, updates momenta then positions one body
// per cycle, and streams the updated positions/masses back out on a valid/ready port.
module nbody_verlet_integrator
  import nbody_pkg::*;
#(
  parameter int  N  = 2,
  parameter real DT = 1.0e-3,
  localparam int IW = $clog2(N),
  localparam int FW = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_idx,
  input  vec3_t         ld_q,
  input  vec3_t         ld_p,
  input  real           ld_m,
  input  logic          start,
  input  logic          f_valid,
  output logic          f_ready,
  // One extra index bit so out-of-range beats are representable and can be dropped.
  input  logic [FW-1:0] f_idx,
  input  vec3_t         f_vec,
  input  logic          f_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output vec3_t         q_out,
  output real           m_out,
  output logic          busy,
  output logic          done
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // a producer holds its payload stable while valid is high and ready is low.

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  vec3_t         q_q [N];
  vec3_t         q_d [N];
  vec3_t         p_q [N];
  vec3_t         p_d [N];
  vec3_t         facc_q [N];
  vec3_t         facc_d [N];
  real           m_q [N];
  real           m_d [N];
  logic          out_valid_q, out_valid_d;
  logic          done_q, done_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [IW-1:0] nxt_idx;
  vec3_t         q_out_q, q_out_d;
  real           m_out_q, m_out_d;

  vec3_t ax_y, ax_x, ax_r;
  real   ax_a;

  always_comb begin
    ax_y = p_q[i_q];
    ax_x = facc_q[i_q];
    ax_a = DT;
    if (state_q == ST_DRIFT) begin
      ax_y = q_q[i_q];
      ax_x = p_q[i_q];
      // Massless bodies are not moved; a zero scale keeps the unused result finite.
      ax_a = (m_q[i_q] != 0.0) ? DT / m_q[i_q] : 0.0;
    end
  end

  nbody_vec3_axpy u_axpy (
    .y (ax_y),
    .x (ax_x),
    .a (ax_a),
    .r (ax_r)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    q_d         = q_q;
    p_d         = p_q;
    facc_d      = facc_q;
    m_d         = m_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    out_idx_d   = out_idx_q;
    q_out_d     = q_out_q;
    m_out_d     = m_out_q;
    nxt_idx     = out_idx_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (ld_valid) begin
          q_d[ld_idx] = ld_q;
          p_d[ld_idx] = ld_p;
          m_d[ld_idx] = ld_m;
        end
        if (start) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (f_valid) begin
          if (f_idx < FW'(N)) begin
            for (int k = 0; k < 3; k++) begin
              facc_d[f_idx[IW-1:0]][k] = facc_q[f_idx[IW-1:0]][k] + f_vec[k];
            end
          end
          if (f_last) begin
            state_d = ST_KICK;
            i_d     = '0;
          end
        end
      end
      ST_KICK: begin
        p_d[i_q]    = ax_r;
        facc_d[i_q] = '{0.0, 0.0, 0.0};
        if (i_q == IW'(N - 1)) begin
          state_d = ST_DRIFT;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_DRIFT: begin
        if (m_q[i_q] != 0.0) begin
          q_d[i_q] = ax_r;
        end
        if (i_q == IW'(N - 1)) begin
          state_d = ST_EMIT;
          i_d     = '0;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_EMIT: begin
        // First EMIT cycle registers body 0; the output stage is fully registered.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          q_out_d     = q_q[0];
          m_out_d     = m_q[0];
        end else if (out_ready) begin
          if (out_idx_q == IW'(N - 1)) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            out_idx_d = nxt_idx;
            q_out_d   = q_q[nxt_idx];
            m_out_d   = m_q[nxt_idx];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_idx_q   <= '0;
      q_out_q     <= '{0.0, 0.0, 0.0};
      m_out_q     <= 0.0;
      for (int b = 0; b < N; b++) begin
        q_q[b]    <= '{0.0, 0.0, 0.0};
        p_q[b]    <= '{0.0, 0.0, 0.0};
        facc_q[b] <= '{0.0, 0.0, 0.0};
        m_q[b]    <= 0.0;
      end
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_idx_q   <= out_idx_d;
      q_out_q     <= q_out_d;
      m_out_q     <= m_out_d;
      q_q         <= q_d;
      p_q         <= p_d;
      facc_q      <= facc_d;
      m_q         <= m_d;
    end
  end

  assign f_ready   = (state_q == ST_ACCUM);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign out_idx   = out_idx_q;
  assign q_out     = q_out_q;
  assign m_out     = m_out_q;

endmodule

// File: tb/tb_nbody_verlet_integrator.sv
// Directed bench for nbody_verlet_integrator with N=2, DT=0.5 and hand-computed results.
module tb_nbody_verlet_integrator;
  import nbody_pkg::*;

  localparam int  N  = 2;
  localparam real DT = 0.5;
  localparam int  IW = $clog2(N);
  localparam int  FW = IW + 1;

  logic          clk;
  logic          rst_n;
  logic          ld_valid;
  logic [IW-1:0] ld_idx;
  vec3_t         ld_q;
  vec3_t         ld_p;
  real           ld_m;
  logic          start;
  logic          f_valid;
  logic          f_ready;
  logic [FW-1:0] f_idx;
  vec3_t         f_vec;
  logic          f_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  vec3_t         q_out;
  real           m_out;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int  exp_idx[$];
  real exp_qx[$];
  real exp_qy[$];
  real exp_qz[$];
  real exp_m[$];

  nbody_verlet_integrator #(.N(N), .DT(DT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_idx    (ld_idx),
    .ld_q      (ld_q),
    .ld_p      (ld_p),
    .ld_m      (ld_m),
    .start     (start),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_idx     (f_idx),
    .f_vec     (f_vec),
    .f_last    (f_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .q_out     (q_out),
    .m_out     (m_out),
    .busy      (busy),
    .done      (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic load_body(input int idx, input real qx, input real qy, input real qz,
                           input real px, input real py, input real pz, input real m);
    ld_valid = 1'b1;
    ld_idx   = IW'(idx);
    ld_q     = '{qx, qy, qz};
    ld_p     = '{px, py, pz};
    ld_m     = m;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int idx, input real fx, input bit last);
    int n;
    f_valid = 1'b1;
    f_idx   = FW'(idx);
    f_vec   = '{fx, 0.0, 0.0};
    f_last  = last;
    n = 0;
    while (f_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: f_ready=%b after %0d cycles, want 1", f_ready, n);
    end
    tick();
    acc_cyc = cyc;
    f_valid = 1'b0;
    f_last  = 1'b0;
  endtask

  // Scoreboard
  task automatic expect_body(input int idx, input real qx, input real qy, input real qz,
                             input real m);
    exp_idx.push_back(idx);
    exp_qx.push_back(qx);
    exp_qy.push_back(qy);
    exp_qz.push_back(qz);
    exp_m.push_back(m);
  endtask

  task automatic clear_expect();
    exp_idx.delete();
    exp_qx.delete();
    exp_qy.delete();
    exp_qz.delete();
    exp_m.delete();
  endtask

  task automatic run_emit(input string tag, input int stall);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_out_valid: out_valid=%b, want 1", tag, out_valid);
      clear_expect();
      return;
    end
    tests++;
    if (cyc - acc_cyc !== 2 * N + 1) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, want %0d", tag, cyc - acc_cyc, 2 * N + 1);
    end
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) begin
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== IW'(exp_idx[0]) || q_out[0] != exp_qx[0] ||
            m_out != exp_m[0]) begin
          fails++;
          $display("FAIL %s_hold: valid=%b idx=%0d qx=%f m=%f, want 1 %0d %f %f", tag,
                   out_valid, out_idx, q_out[0], m_out, exp_idx[0], exp_qx[0], exp_m[0]);
        end
      end
      out_ready = 1'b1;
    end
    n = 0;
    while (exp_idx.size() > 0 && n < 40) begin
      if (out_valid === 1'b1) begin
        tests++;
        if (out_idx !== IW'(exp_idx[0]) || q_out[0] != exp_qx[0] || q_out[1] != exp_qy[0] ||
            q_out[2] != exp_qz[0] || m_out != exp_m[0]) begin
          fails++;
          $display("FAIL %s_body: idx=%0d q=(%f,%f,%f) m=%f, want idx=%0d q=(%f,%f,%f) m=%f",
                   tag, out_idx, q_out[0], q_out[1], q_out[2], m_out, exp_idx[0],
                   exp_qx[0], exp_qy[0], exp_qz[0], exp_m[0]);
        end
        void'(exp_idx.pop_front());
        void'(exp_qx.pop_front());
        void'(exp_qy.pop_front());
        void'(exp_qz.pop_front());
        void'(exp_m.pop_front());
      end
      tick();
      n++;
    end
    if (exp_idx.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_emit_timeout: %0d bodies not emitted", tag, exp_idx.size());
      clear_expect();
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: done=%b busy=%b out_valid=%b, want 1 0 0", tag, done, busy,
               out_valid);
    end
    tick();
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_done_pulse: done=%b out_valid=%b, want 0 0", tag, done, out_valid);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (f_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_idx !== '0 || q_out[0] != 0.0 || q_out[1] != 0.0 || q_out[2] != 0.0 ||
        m_out != 0.0) begin
      fails++;
      $display("FAIL reset_outputs: f_ready=%b out_valid=%b busy=%b done=%b idx=%0d m=%f, want 0",
               f_ready, out_valid, busy, done, out_idx, m_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_step(input string tag, input int stall);
    load_body(0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 1.0);
    load_body(1, 1.0, 0.0, 0.0, 0.0, 0.0, 0.0, 2.0);
    pulse_start();
    send_beat(0, 2.0, 1'b0);
    send_beat(1, -2.0, 1'b1);
    expect_body(0, 0.5, 0.0, 0.0, 1.0);
    expect_body(1, 0.75, 0.0, 0.0, 2.0);
    run_emit(tag, stall);
  endtask

  task automatic test_bad_index();
    load_body(0, 0.0, 0.0, 0.0, 1.0, 0.0, 0.0, 1.0);
    load_body(1, 1.0, 0.0, 0.0, 0.0, 0.0, 0.0, 2.0);
    pulse_start();
    send_beat(3, 100.0, 1'b1);
    tests++;
    if (f_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL bad_idx_kick: f_ready=%b busy=%b, want 0 1", f_ready, busy);
    end
    expect_body(0, 0.5, 0.0, 0.0, 1.0);
    expect_body(1, 1.0, 0.0, 0.0, 2.0);
    run_emit("bad_idx", 0);
  endtask

  task automatic test_zero_mass();
    load_body(0, 0.0, 0.0, 0.0, 2.0, 0.0, 0.0, 1.0);
    load_body(1, 1.0, 2.0, 3.0, 0.0, 0.0, 0.0, 0.0);
    pulse_start();
    send_beat(1, 8.0, 1'b1);
    expect_body(0, 1.0, 0.0, 0.0, 1.0);
    expect_body(1, 1.0, 2.0, 3.0, 0.0);
    run_emit("zero_mass", 0);
  endtask

  task automatic test_reset_mid_kick();
    load_body(0, 3.0, 0.0, 0.0, 1.0, 0.0, 0.0, 1.0);
    load_body(1, 4.0, 0.0, 0.0, 1.0, 0.0, 0.0, 1.0);
    pulse_start();
    send_beat(0, 2.0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (f_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_idx !== '0 || q_out[0] != 0.0 || q_out[1] != 0.0 || q_out[2] != 0.0 ||
        m_out != 0.0) begin
      fails++;
      $display("FAIL kick_reset_outputs: f_ready=%b out_valid=%b busy=%b done=%b idx=%0d qx=%f m=%f, want 0",
               f_ready, out_valid, busy, done, out_idx, q_out[0], m_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_beat(0, 0.0, 1'b1);
    expect_body(0, 0.0, 0.0, 0.0, 0.0);
    expect_body(1, 0.0, 0.0, 0.0, 0.0);
    run_emit("post_reset_clear", 0);
    test_basic_step("post_reset_step", 0);
  endtask

  task automatic test_accum_ignores();
    load_body(0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 1.0);
    load_body(1, 1.0, 0.0, 0.0, 0.0, 0.0, 0.0, 2.0);
    pulse_start();
    start    = 1'b1;
    ld_valid = 1'b1;
    ld_idx   = '0;
    ld_q     = '{9.0, 9.0, 9.0};
    ld_p     = '{9.0, 9.0, 9.0};
    ld_m     = 5.0;
    tick();
    start    = 1'b0;
    ld_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || f_ready !== 1'b1) begin
      fails++;
      $display("FAIL accum_ignore_state: busy=%b f_ready=%b, want 1 1", busy, f_ready);
    end
    send_beat(0, 2.0, 1'b0);
    send_beat(1, -2.0, 1'b1);
    expect_body(0, 0.5, 0.0, 0.0, 1.0);
    expect_body(1, 0.75, 0.0, 0.0, 2.0);
    run_emit("accum_ignore", 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    ld_valid  = 1'b0;
    ld_idx    = '0;
    ld_q      = '{0.0, 0.0, 0.0};
    ld_p      = '{0.0, 0.0, 0.0};
    ld_m      = 0.0;
    start     = 1'b0;
    f_valid   = 1'b0;
    f_idx     = '0;
    f_vec     = '{0.0, 0.0, 0.0};
    f_last    = 1'b0;
    out_ready = 1'b1;

    test_reset();
    test_basic_step("basic", 0);
    test_basic_step("backpressure", 3);
    test_bad_index();
    test_zero_mass();
    test_reset_mid_kick();
    test_accum_ignores();

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
